// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings,
// fault codes and FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper: byte enables, store lane replication and
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_ext
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    load_ext  = rdata;
    case (f3)
      F3_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        load_ext  = {{24{b[7]}}, b};
      end
      F3_BU: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        load_ext  = {24'd0, b};
      end
      F3_H: begin
        be        = 4'b0011 << {off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        load_ext  = {{16{h[15]}}, h};
      end
      F3_HU: begin
        be        = 4'b0011 << {off[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        load_ext  = {16'd0, h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit: one aligned bus transaction per
// MEM-stage access, stalling the pipeline until ack or timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_wr_en,
  input  logic [2:0]  mem_control,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] ld_q, ld_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        access;
  logic        ld_bad;
  logic        st_bad;
  logic        illegal;
  logic        misal;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign access  = req_valid & (mem_read | mem_wr_en);
  assign ld_bad  = (mem_control == 3'b011) || (mem_control[2:1] == 2'b11);
  assign st_bad  = mem_control > F3_W;
  assign illegal = (mem_read & mem_wr_en)
                 | (mem_read & ld_bad)
                 | (mem_wr_en & st_bad);
  assign misal   = ALIGN_CHECK
                 && (((mem_control[1:0] == 2'b01) && addr[0])
                 ||  ((mem_control[1:0] == 2'b10) && (addr[1:0] != 2'b00)));

  // Live request while idle, latched request while waiting for ack
  assign al_f3  = (state_q == ST_IDLE) ? mem_control : f3_q;
  assign al_off = (state_q == ST_IDLE) ? addr[1:0] : off_q;

  lsu_align u_align (
    .f3        (al_f3),
    .off       (al_off),
    .wdata     (wdata),
    .rdata     (bus_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .load_ext  (al_load)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    we_d    = we_q;
    wd_d    = wd_q;
    ld_d    = ld_q;
    err_d   = err_q;
    code_d  = code_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = access & ~rst;
        if (access) begin
          f3_d  = mem_control;
          off_d = addr[1:0];
          if (illegal || misal) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            code_d  = illegal ? ERR_ILLEGAL : ERR_MISALIGN;
            ld_d    = 32'd0;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = 16'd0;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = al_be;
            we_d    = mem_wr_en;
            wd_d    = mem_wr_en ? al_wdata : 32'd0;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (bus_ack) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          ld_d    = we_q ? 32'd0 : al_load;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          ld_d    = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      wd_q    <= 32'd0;
      ld_q    <= 32'd0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus_req   = (state_q == ST_BUSY);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wd_q;
  assign load_data = ld_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed steps then
// randomized accesses against an arithmetic reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        mem_read;
  logic        mem_wr_en;
  logic [2:0]  mem_control;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  logic [1:0]  err_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT(TO), .ALIGN_CHECK(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .mem_read    (mem_read),
    .mem_wr_en   (mem_wr_en),
    .mem_control (mem_control),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .done        (done),
    .load_data   (load_data),
    .err         (err),
    .err_code    (err_code),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: outcome of one access from the ISA-level rules
  task automatic model(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rw, input int ack_at,
                       output logic [3:0] be, output logic [31:0] wrep,
                       output logic [31:0] ld, output bit e,
                       output logic [1:0] code, output int lat);
    int size;
    int off;
    bit ill;
    bit mis;
    longint raw;
    longint mask;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill  = (rd && wr)
        || (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
        || (wr && f3 > 3'd2);
    mis  = !ill && ((a % size) != 0);
    off  = int'(a % 4) / size * size;
    be   = 4'(((1 << size) - 1) << off);
    if (size == 1)      wrep = {24'd0, wd[7:0]} * 32'h0101_0101;
    else if (size == 2) wrep = {16'd0, wd[15:0]} * 32'h0001_0001;
    else                wrep = wd;
    mask = (64'd1 << (8 * size)) - 1;
    raw  = (longint'(rw) >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && raw >= (mask + 1) / 2)
      raw = raw - (mask + 1);
    ld = 32'(raw);
    e = 0; code = 2'd0;
    if (ill || mis) begin
      e = 1; code = ill ? 2'd2 : 2'd1; ld = 0; lat = 2;
    end else if (ack_at < 1 || ack_at > TO) begin
      e = 1; code = 2'd3; ld = 0; lat = TO + 2;
    end else begin
      lat = ack_at + 2;
      if (wr) ld = 0;
    end
  endtask

  task automatic run(input string nm, input bit rd, input bit wr,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rw,
                     input int ack_at);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] eld;
    bit          ee;
    logic [1:0]  ec;
    int          elat;
    int          n;
    int          busy;
    bit          seen_req;
    bit          got;
    model(rd, wr, f3, a, wd, rw, ack_at, ebe, ewd, eld, ee, ec, elat);
    @(negedge clk);
    req_valid = 1; mem_read = rd; mem_wr_en = wr;
    mem_control = f3; addr = a; wdata = wd; bus_ack = 0;
    #1 check({nm, ".stall_accept"}, stall, 1);
    @(negedge clk);
    req_valid = 0; mem_read = 0; mem_wr_en = 0;
    mem_control = 3'($urandom); addr = $urandom; wdata = $urandom;
    n = 1; busy = 0; seen_req = 0; got = 0;
    while (!got && n < 64) begin
      bus_ack = 0;
      bus_rdata = $urandom;
      if (bus_req) begin
        busy++;
        seen_req = 1;
        if (busy == 1) begin
          check({nm, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
          check({nm, ".bus_be"}, 32'(bus_be), 32'(ebe));
          check({nm, ".bus_we"}, 32'(bus_we), 32'(wr));
          if (wr) check({nm, ".bus_wdata"}, bus_wdata, ewd);
        end
        check({nm, ".stall_busy"}, stall, 1);
        if (busy == ack_at) begin
          bus_ack = 1;
          bus_rdata = rw;
        end
      end else if (done) begin
        got = 1;
      end
      if (!got) begin
        @(negedge clk);
        n++;
      end
    end
    bus_ack = 0;
    check({nm, ".done_seen"}, 32'(got), 1);
    check({nm, ".latency"}, n + 1, elat);
    if (ee && ec != 2'd3) check({nm, ".no_bus_req"}, 32'(seen_req), 0);
    check({nm, ".err"}, 32'(err), 32'(ee));
    check({nm, ".err_code"}, 32'(err_code), 32'(ec));
    check({nm, ".load_data"}, load_data, eld);
    check({nm, ".stall_resp"}, 32'(stall), 0);
    check({nm, ".bus_req_resp"}, 32'(bus_req), 0);
    @(negedge clk);
    check({nm, ".done_pulse"}, 32'(done), 0);
    check({nm, ".load_hold"}, load_data, eld);
  endtask

  initial begin
    bit         rd_r;
    bit         wr_r;
    int         k;
    rst = 1; req_valid = 0; mem_read = 0; mem_wr_en = 0;
    mem_control = 0; addr = 0; wdata = 0; bus_ack = 0; bus_rdata = 0;
    #12;
    check("rst.stall", 32'(stall), 0);
    check("rst.done", 32'(done), 0);
    check("rst.bus_req", 32'(bus_req), 0);
    check("rst.bus_addr", bus_addr, 0);
    check("rst.bus_be", 32'(bus_be), 0);
    check("rst.bus_wdata", bus_wdata, 0);
    check("rst.load_data", load_data, 0);
    check("rst.err", {29'd0, err, err_code}, 0);
    @(negedge clk);
    rst = 0;

    run("sw", 0, 1, F3_W, 32'h104, 32'hDEADBEEF, 32'h0, 1);
    run("lb", 1, 0, F3_B, 32'h203, 32'h0, 32'h80FF_1234, 1);
    check("lb.value", load_data, 32'hFFFF_FF80);
    run("lbu", 1, 0, F3_BU, 32'h203, 32'h0, 32'h80FF_1234, 1);
    check("lbu.value", load_data, 32'h0000_0080);
    run("lhu_wait", 1, 0, F3_HU, 32'h202, 32'h0, 32'hBEEF_0000, 4);
    check("lhu.value", load_data, 32'h0000_BEEF);
    run("lw_mis", 1, 0, F3_W, 32'h101, 32'h0, 32'h1234_5678, 1);
    run("ld_ill", 1, 0, 3'b011, 32'h100, 32'h0, 32'h1234_5678, 1);
    run("rdwr_ill", 1, 1, 3'b101, 32'h101, 32'h0, 32'h0, 1);
    run("sb_tmo", 0, 1, F3_B, 32'h3, 32'h5A, 32'h0, 0);
    run("sh_hi", 0, 1, F3_H, 32'h12, 32'hCAFE_1357, 32'h0, 2);

    // Acknowledges while idle must not start anything
    @(negedge clk);
    bus_ack = 1;
    @(negedge clk);
    check("idle_ack.done", 32'(done), 0);
    check("idle_ack.bus_req", 32'(bus_req), 0);
    bus_ack = 0;

    // Reset in the middle of a transaction
    @(negedge clk);
    req_valid = 1; mem_read = 1; mem_control = F3_W; addr = 32'h40;
    @(negedge clk);
    req_valid = 0; mem_read = 0;
    check("mid.bus_req", 32'(bus_req), 1);
    #2 rst = 1;
    #1;
    check("mid_rst.bus_req", 32'(bus_req), 0);
    check("mid_rst.stall", 32'(stall), 0);
    check("mid_rst.done", 32'(done), 0);
    check("mid_rst.bus_addr", bus_addr, 0);
    @(negedge clk);
    rst = 0;
    run("lw_after_rst", 1, 0, F3_W, 32'h40, 32'h0, 32'h0BAD_F00D, 2);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      rd_r = (k < 5) || (k == 9);
      wr_r = (k >= 5);
      run("rand", rd_r, wr_r, 3'($urandom_range(0, 7)),
          $urandom, $urandom, $urandom, $urandom_range(1, TO + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
